multicycle_ctrl_fsm: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 64 ++++++
 rtl/mc_ctrl_decode.sv | 88 ++++++++
 rtl/multicycle_ctrl_fsm.sv | 115 +++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: opcode values, ALU
// operation codes handed to the ALU control circuit, datapath mux encodings,
// the FSM state type and a bundled struct of all control outputs.
package cpu_ctrl_pkg;

    // Opcode field values (compared after resizing to the opcode width)
    localparam int OPC_R    = 0;
    localparam int OPC_ADDI = 1;
    localparam int OPC_LW   = 2;
    localparam int OPC_SW   = 3;
    localparam int OPC_BEQ  = 4;
    localparam int OPC_J    = 5;

    // ALUopt encodings; funct decoding stays in the ALU control circuit
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRC_B_RT   = 2'b00;
    localparam logic [1:0] SRC_B_ONE  = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;
    localparam logic [1:0] SRC_B_BOFF = 2'b11;

    // Controller states; codes 13..15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_R_EXEC   = 4'd2,
        ST_R_WB     = 4'd3,
        ST_I_EXEC   = 4'd4,
        ST_I_WB     = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_MEM_WB   = 4'd8,
        ST_MEM_WR   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_HALT     = 4'd12
    } state_t;

    // All controller outputs in one bundle so they can be cleared together
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-outputs decoder for the multi-cycle controller.
// Ports:
//   state     in   current controller state
//   zero      in   ALU zero flag (qualifies the branch PC write)
//   mem_ready in   memory access completes this cycle (qualifies fetch strobes)
//   ctrl      out  bundled datapath selects and strobes
module mc_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   zero,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRC_B_ONE;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_SRC_ALU;
                // IR and PC load only on the cycle the fetch completes
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                // Precompute the branch target into ALUOut
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRC_B_BOFF;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_RT;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ST_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            ST_I_EXEC, ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
            end
            ST_MEM_RD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.iord    = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_RT;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PC_SRC_ALUOUT;
                ctrl.pc_write  = zero;
            end
            ST_JUMP: begin
                ctrl.pc_src   = PC_SRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            ST_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control FSM: sequences fetch, decode, execute, memory and
// writeback for the MIPS-like core and handshakes with a variable-latency
// unified memory.
// Ports:
//   clk, rst          clock (rising edge) and synchronous active-high reset
//   opcode            instruction-register opcode field
//   zero              ALU zero flag
//   mem_ready         memory completes the current access this cycle
//   mem_req, mem_we   memory request / write qualifier
//   iord              memory address select (0 PC, 1 ALUOut)
//   ir_write, pc_write  IR and PC load strobes
//   pc_src            PC source select
//   alu_src_a/_b      ALU operand selects
//   ALUopt            operation code to the ALU control circuit
//   reg_write, reg_dst, mem_to_reg  register file writeback controls
//   halted            controller is in HALT
module multicycle_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W            = 4,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic            iord,
    output logic            ir_write,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      ALUopt,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            halted
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  dec_ctrl;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = ST_FETCH;
        case (state_reg)
            ST_FETCH:    state_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (opcode == OP_W'(OPC_R)) begin
                    state_next = ST_R_EXEC;
                end else if (opcode == OP_W'(OPC_ADDI)) begin
                    state_next = ST_I_EXEC;
                end else if (opcode == OP_W'(OPC_LW) || opcode == OP_W'(OPC_SW)) begin
                    state_next = ST_MEM_ADDR;
                end else if (opcode == OP_W'(OPC_BEQ)) begin
                    state_next = ST_BRANCH;
                end else if (opcode == OP_W'(OPC_J)) begin
                    state_next = ST_JUMP;
                end else begin
                    state_next = HALT_ON_ILLEGAL ? ST_HALT : ST_FETCH;
                end
            end
            ST_R_EXEC:   state_next = ST_R_WB;
            ST_R_WB:     state_next = ST_FETCH;
            ST_I_EXEC:   state_next = ST_I_WB;
            ST_I_WB:     state_next = ST_FETCH;
            ST_MEM_ADDR: state_next = (opcode == OP_W'(OPC_SW)) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   state_next = mem_ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:   state_next = ST_FETCH;
            ST_MEM_WR:   state_next = mem_ready ? ST_FETCH : ST_MEM_WR;
            ST_BRANCH:   state_next = ST_FETCH;
            ST_JUMP:     state_next = ST_FETCH;
            ST_HALT:     state_next = ST_HALT;
            default:     state_next = ST_FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state     (state_reg),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ctrl      (dec_ctrl)
    );

    // Reset silences every output in the same cycle, so an access that
    // completes while rst is high cannot fire a write strobe.
    assign ctrl = rst ? '0 : dec_ctrl;

    assign mem_req    = ctrl.mem_req;
    assign mem_we     = ctrl.mem_we;
    assign iord       = ctrl.iord;
    assign ir_write   = ctrl.ir_write;
    assign pc_write   = ctrl.pc_write;
    assign pc_src     = ctrl.pc_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign ALUopt     = ctrl.alu_op;
    assign reg_write  = ctrl.reg_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign halted     = ctrl.halted;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: a sequence-table model of
// each instruction's micro-steps is compared against the DUT every cycle,
// and directed instruction runs check hand-computed literal expectations.
module tb_multicycle_ctrl_fsm;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src, alu_src_b, ALUopt;
    logic       alu_src_a, reg_write, reg_dst, mem_to_reg, halted;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluopt;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       halted;
    } ov_t;

    multicycle_ctrl_fsm #(.OP_W(4), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ALUopt     (ALUopt),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic ov_t dut_vec();
        ov_t v;
        v = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
             alu_src_b, ALUopt, reg_write, reg_dst, mem_to_reg, halted};
        return v;
    endfunction

    // ---------------- reference model ----------------
    // Each instruction is a fixed list of micro-steps; position 0 is the
    // fetch, position 1 the decode, the rest depend on the opcode.
    localparam int S_FETCH = 0, S_DEC = 1, S_REX = 2, S_RWB = 3, S_IEX = 4,
                   S_IWB = 5, S_ADDR = 6, S_RD = 7, S_LWB = 8, S_WR = 9,
                   S_BR = 10, S_JMP = 11, S_HLT = 12;

    function automatic int step_at(input int op, input int pos);
        if (pos == 0) return S_FETCH;
        if (pos == 1) return S_DEC;
        case (op)
            0: return (pos == 2) ? S_REX : S_RWB;
            1: return (pos == 2) ? S_IEX : S_IWB;
            2: return (pos == 2) ? S_ADDR : ((pos == 3) ? S_RD : S_LWB);
            3: return (pos == 2) ? S_ADDR : S_WR;
            4: return S_BR;
            5: return S_JMP;
            default: return S_HLT;
        endcase
    endfunction

    // Instruction lengths with no memory stalls
    function automatic int seq_len(input int op);
        case (op)
            0, 1, 3: return 4;
            2:       return 5;
            default: return 3;
        endcase
    endfunction

    function automatic int next_pos(input int op, input int pos, input logic rdy);
        int s;
        s = step_at(op, pos);
        if (s == S_HLT) return pos;
        if ((s == S_FETCH || s == S_RD || s == S_WR) && !rdy) return pos;
        return (pos + 1 == seq_len(op)) ? 0 : pos + 1;
    endfunction

    function automatic ov_t model_out(input logic r, input int s, input logic z, input logic rdy);
        ov_t o;
        o = '0;
        if (!r) begin
            case (s)
                S_FETCH: begin o.mem_req = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
                S_DEC:   o.alu_src_b = 2'b11;
                S_REX:   begin o.alu_src_a = 1; o.aluopt = 2'b10; end
                S_RWB:   begin o.reg_write = 1; o.reg_dst = 1; end
                S_IEX, S_ADDR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
                S_IWB:   o.reg_write = 1;
                S_RD:    begin o.mem_req = 1; o.iord = 1; end
                S_LWB:   begin o.reg_write = 1; o.mem_to_reg = 1; end
                S_WR:    begin o.mem_req = 1; o.mem_we = 1; o.iord = 1; end
                S_BR:    begin o.alu_src_a = 1; o.aluopt = 2'b01; o.pc_src = 2'b01; o.pc_write = z; end
                S_JMP:   begin o.pc_src = 2'b10; o.pc_write = 1; end
                S_HLT:   o.halted = 1;
                default: ;
            endcase
        end
        return o;
    endfunction

    int m_pos = 0;

    always @(posedge clk) begin
        if (rst) m_pos <= 0;
        else     m_pos <= next_pos(int'(opcode), m_pos, mem_ready);
    end

    always @(negedge clk) begin
        check("model_cycle", 32'(dut_vec()),
              32'(model_out(rst, step_at(int'(opcode), m_pos), zero, mem_ready)));
    end

    // ---------------- directed stimulus ----------------
    ov_t obs [1:32];

    // Runs n cycles with the given opcode; bit c of stall_mask drops
    // mem_ready in cycle c. Cycle 1 must always be a fetch.
    task automatic run_instr(input string name, input logic [3:0] op, input int n,
                             input logic [32:0] stall_mask, input logic z);
        opcode = op;
        zero   = z;
        for (int c = 1; c <= n; c++) begin
            mem_ready = !stall_mask[c];
            @(negedge clk);
            obs[c] = dut_vec();
            if (c == 1)
                check({name, "_starts_fetch"}, {obs[1].mem_req, obs[1].iord, obs[1].alu_src_b}, 4'b1001);
            @(posedge clk);
            #1;
        end
        $display("instr %s op=%0d cycles=%0d zero=%0b stalls=%h", name, op, n, z, stall_mask);
    endtask

    initial begin
        int hcnt;
        rst = 1'b1; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_strobes", {mem_req, mem_we, ir_write, pc_write, reg_write, halted}, 6'b0);
        check("rst_all_outputs", 32'(dut_vec()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // R-type
        run_instr("R", 4'd0, 4, 33'd0, 1'b0);
        check("fetch_after_rst", {obs[1].mem_req, obs[1].ir_write, obs[1].pc_write, obs[1].aluopt}, 5'b11100);
        check("r_aluopt_seq", {obs[1].aluopt, obs[2].aluopt, obs[3].aluopt, obs[4].aluopt}, 8'b00_00_10_00);
        check("r_regwrite_seq", {obs[1].reg_write, obs[2].reg_write, obs[3].reg_write, obs[4].reg_write}, 4'b0001);
        check("r_reg_dst", obs[4].reg_dst, 1'b1);

        // ADDI
        run_instr("ADDI", 4'd1, 4, 33'd0, 1'b0);
        check("addi_wb", {obs[4].reg_write, obs[4].reg_dst, obs[3].alu_src_b}, 4'b1010);

        // LW with three wait cycles in the read
        run_instr("LW", 4'd2, 8, 33'h70, 1'b0);
        begin
            logic [7:0] rq;
            logic [7:0] rw;
            for (int c = 1; c <= 8; c++) begin
                rq[8 - c] = obs[c].mem_req & obs[c].iord;
                rw[8 - c] = obs[c].reg_write;
            end
            check("lw_memreq_iord", rq, 8'b0001_1110);
            check("lw_regwrite", rw, 8'b0000_0001);
            check("lw_mem_to_reg", obs[8].mem_to_reg, 1'b1);
        end

        // SW, no wait
        run_instr("SW", 4'd3, 4, 33'd0, 1'b0);
        check("sw_write", {obs[4].mem_req, obs[4].mem_we, obs[4].iord}, 3'b111);

        // BEQ taken / not taken
        run_instr("BEQ_T", 4'd4, 3, 33'd0, 1'b1);
        check("beq_taken", {obs[3].pc_write, obs[3].pc_src, obs[3].aluopt}, 5'b1_01_01);
        run_instr("BEQ_N", 4'd4, 3, 33'd0, 1'b0);
        check("beq_not_taken", {obs[3].pc_write, obs[3].pc_src, obs[3].aluopt}, 5'b0_01_01);

        // J
        run_instr("J", 4'd5, 3, 33'd0, 1'b0);
        check("jump", {obs[3].pc_write, obs[3].pc_src}, 3'b110);

        // ADDI with a one-cycle fetch stall; mem_ready is ignored in decode
        run_instr("ADDI_FSTALL", 4'd1, 5, 33'h2, 1'b0);
        check("fetch_stall", {obs[1].mem_req, obs[1].ir_write, obs[2].mem_req, obs[2].ir_write}, 4'b1011);
        check("fetch_stall_wb", obs[5].reg_write, 1'b1);

        // Illegal opcode halts and stays halted
        run_instr("ILLEGAL", 4'd15, 22, 33'd0, 1'b0);
        hcnt = 0;
        for (int c = 3; c <= 22; c++) hcnt += int'(obs[c].halted);
        check("halt_pre", {obs[1].halted, obs[2].halted}, 2'b00);
        check("halt_sticky_20", hcnt, 20);
        rst = 1'b1;
        @(negedge clk);
        check("halt_rst_forces", {halted, mem_req, pc_write, ir_write}, 4'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_instr("R_AFTER_HALT", 4'd0, 4, 33'd0, 1'b0);

        // SW interrupted by reset while waiting in the write
        run_instr("SW_WAIT", 4'd3, 4, 33'h10, 1'b0);
        check("sw_wait_write", {obs[4].mem_req, obs[4].mem_we}, 2'b11);
        rst = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("sw_rst_no_write", {mem_req, mem_we, reg_write, pc_write, ir_write}, 5'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_instr("R_AFTER_SW_RST", 4'd0, 4, 33'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
